// File: rtl/ps2_rx_filtrado.sv
// PS/2 device-to-host frame receiver: synchronises and deglitches ps2c, shifts in
// an 11-bit frame LSB-first, then validates stop bit and odd parity before releasing the byte.
module ps2_rx_filtrado #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rx_en,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYC - 1);

    logic                  ps2c_meta, ps2c_sync;
    logic                  ps2d_meta, ps2d_sync;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_c, filt_c_prev;
    logic                  fall_tick;

    logic [1:0]  state_reg;
    logic [3:0]  bit_cnt_reg;
    logic [16:0] tmo_reg;
    logic [9:0]  shreg_reg;
    logic [7:0]  dout_reg;
    logic        done_reg, perr_reg, ferr_reg;

    // Idle level of the bus is high, so the conditioning chain resets to ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2c_meta   <= 1'b1;
            ps2c_sync   <= 1'b1;
            ps2d_meta   <= 1'b1;
            ps2d_sync   <= 1'b1;
            filt_sr     <= '1;
            filt_c      <= 1'b1;
            filt_c_prev <= 1'b1;
        end else begin
            ps2c_meta   <= ps2c;
            ps2c_sync   <= ps2c_meta;
            ps2d_meta   <= ps2d;
            ps2d_sync   <= ps2d_meta;
            filt_sr     <= {filt_sr[FILTER_LEN-2:0], ps2c_sync};
            if (&filt_sr)
                filt_c <= 1'b1;
            else if (~|filt_sr)
                filt_c <= 1'b0;
            filt_c_prev <= filt_c;
        end
    end

    assign fall_tick = filt_c_prev & ~filt_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 4'd0;
            tmo_reg     <= 17'd0;
            shreg_reg   <= 10'd0;
            dout_reg    <= 8'h00;
            done_reg    <= 1'b0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            perr_reg <= 1'b0;
            ferr_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (fall_tick && rx_en && !ps2d_sync) begin
                        state_reg   <= RECV;
                        bit_cnt_reg <= 4'd10;
                        tmo_reg     <= 17'd0;
                    end
                end
                RECV: begin
                    // An edge arriving on the timeout cycle still counts as a bit.
                    if (fall_tick) begin
                        shreg_reg   <= {ps2d_sync, shreg_reg[9:1]};
                        bit_cnt_reg <= bit_cnt_reg - 4'd1;
                        tmo_reg     <= 17'd0;
                        if (bit_cnt_reg == 4'd1)
                            state_reg <= CHECK;
                    end else if (tmo_reg == TMO_LAST) begin
                        ferr_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else if (tmo_reg != 17'h1FFFF) begin
                        tmo_reg <= tmo_reg + 17'd1;
                    end
                end
                CHECK: begin
                    state_reg <= IDLE;
                    if (!shreg_reg[9])
                        ferr_reg <= 1'b1;
                    else if (!(^shreg_reg[8:0]))
                        perr_reg <= 1'b1;
                    else begin
                        done_reg <= 1'b1;
                        dout_reg <= shreg_reg[7:0];
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rx_done_tick = done_reg;
    assign parity_err   = perr_reg;
    assign frame_err    = ferr_reg;
    assign dout         = dout_reg;
    assign busy         = (state_reg != IDLE);
endmodule
